// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Constants, coefficient set, state encoding and saturation
//                helpers shared by the forward FIR and its deconvolver.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int N      = 4;
    localparam int WIDTH  = 8;
    localparam int COEFFS [0:N-1] = '{1, 2, 3, 4};

    // Accumulator must hold a 2*WIDTH sample plus N-1 product subtractions
    function automatic int acc_width(input int taps, input int w);
        return 2 * w + $clog2(taps);
    endfunction

    localparam int ACC_W = acc_width(N, WIDTH);
    localparam int K_W   = (N > 2) ? $clog2(N) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // True when the accumulator lies outside the WIDTH-bit signed range
    function automatic logic is_ovf(input logic signed [ACC_W-1:0] a);
        return (a > SAT_MAX) || (a < SAT_MIN);
    endfunction

    // Clamp accumulator to the WIDTH-bit signed range
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else if (a < SAT_MIN) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return a[WIDTH-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_deconv_mac.sv
`default_nettype none
// ============================================================================
//  Module      : fir_deconv_mac
//  Description : Single-multiplier accumulator. Loads a sign-extended y sample
//                or subtracts h[k]*hist from the running accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_deconv_mac
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_load,
    input  logic                     i_sub,
    input  logic signed [2*WIDTH-1:0] i_y,
    input  logic [K_W-1:0]           i_k,
    input  logic signed [WIDTH-1:0]  i_hist,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [ACC_W-1:0]   r_acc;
    logic signed [WIDTH-1:0]   w_coef;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_y_ext;

    // Coefficient selected by the current tap index
    always_comb begin
        w_coef = '0;
        for (int i = 0; i < N; i++) begin
            if (i_k == K_W'(i)) begin
                w_coef = WIDTH'(COEFFS[i]);
            end
        end
    end

    assign w_prod     = w_coef * i_hist;
    assign w_prod_ext = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_y_ext    = {{(ACC_W-2*WIDTH){i_y[2*WIDTH-1]}}, i_y};

    // Accumulator: clear has priority, then load of a new sample, then subtract
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_y_ext;
        end else if (i_sub) begin
            r_acc <= r_acc - w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/fir_deconvolver.sv
`default_nettype none
// ============================================================================
//  Module      : fir_deconvolver
//  Description : Recursive inverse of the h={1,2,3,4} FIR. Recovers x[n] from
//                y[n] with one time-shared MAC; one sample per N+1 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_deconvolver
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [2*WIDTH-1:0] y_in,
    input  logic                      y_valid,
    output logic                      y_ready,
    input  logic                      clear,
    output logic signed [WIDTH-1:0]   x_out,
    output logic                      x_valid,
    output logic                      ovf
);

    state_t                   r_state;
    logic [K_W-1:0]           r_k;
    logic signed [WIDTH-1:0]  r_hist [0:N-2];
    logic signed [WIDTH-1:0]  r_x_out;
    logic                     r_x_valid;
    logic                     r_ovf;

    logic                     w_load;
    logic                     w_sub;
    logic signed [WIDTH-1:0]  w_hist_sel;
    logic signed [ACC_W-1:0]  w_acc;

    assign y_ready = (r_state == ST_IDLE);
    assign w_load  = y_ready && y_valid && !clear;
    assign w_sub   = (r_state == ST_MAC) && !clear;

    // History operand for tap k is x[n-k], stored at hist[k-1]
    always_comb begin
        w_hist_sel = '0;
        for (int j = 0; j < N - 1; j++) begin
            if (r_k == K_W'(j + 1)) begin
                w_hist_sel = r_hist[j];
            end
        end
    end

    fir_deconv_mac u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_load  (w_load),
        .i_sub   (w_sub),
        .i_y     (y_in),
        .i_k     (r_k),
        .i_hist  (w_hist_sel),
        .o_acc   (w_acc)
    );

    // Sequencer, history shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_x_out   <= '0;
            r_x_valid <= 1'b0;
            r_ovf     <= 1'b0;
            for (int j = 0; j < N - 1; j++) begin
                r_hist[j] <= '0;
            end
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_x_valid <= 1'b0;
            r_ovf     <= 1'b0;
            for (int j = 0; j < N - 1; j++) begin
                r_hist[j] <= '0;
            end
        end else begin
            r_x_valid <= 1'b0;
            r_ovf     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (y_valid) begin
                        r_k     <= K_W'(1);
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_k == K_W'(N - 1)) begin
                        r_k     <= '0;
                        r_state <= ST_OUT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                ST_OUT: begin
                    r_x_out   <= sat(w_acc);
                    r_ovf     <= is_ovf(w_acc);
                    r_x_valid <= 1'b1;
                    // The clamped value, not the raw accumulator, feeds back
                    for (int j = N - 2; j > 0; j--) begin
                        r_hist[j] <= r_hist[j-1];
                    end
                    r_hist[0] <= sat(w_acc);
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_out   = r_x_out;
    assign x_valid = r_x_valid;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fir_deconvolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_deconvolver
//  Description : Directed self-checking bench for fir_deconvolver.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_deconvolver;

    logic               clk;
    logic               rst;
    logic signed [15:0] y_in;
    logic               y_valid;
    logic               y_ready;
    logic               clear;
    logic signed [7:0]  x_out;
    logic               x_valid;
    logic               ovf;

    int tests;
    int fails;

    fir_deconvolver dut (
        .clk     (clk),
        .rst     (rst),
        .y_in    (y_in),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .clear   (clear),
        .x_out   (x_out),
        .x_valid (x_valid),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one sample, then wait (bounded) for the x_valid pulse.
    // lat = edges from the accept edge to the edge that raised x_valid, -1 if none.
    task automatic run_sample(input logic signed [15:0] y, output logic signed [7:0] x,
                              output logic o, output int lat);
        int w;
        w = 0;
        while (!y_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        y_in    = y;
        y_valid = 1'b1;
        @(posedge clk); #1;
        y_valid = 1'b0;
        lat = -1;
        x   = '0;
        o   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (x_valid) begin
                lat = c;
                x   = x_out;
                o   = ovf;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; y_in = '0; y_valid = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({x_out, x_valid, ovf, y_ready} !== {8'sd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset: x_out=%0d x_valid=%b ovf=%b y_ready=%b, want 0 0 0 1",
                     x_out, x_valid, ovf, y_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        int ys [6] = '{1, 2, 3, 4, 0, 0};
        int xs [6] = '{1, 0, 0, 0, 0, 0};
        logic signed [7:0] x;
        logic o;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_sample(16'(ys[i]), x, o, lat);
            tests++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL impulse[%0d] latency: got %0d want 4", i, lat);
            end
            tests++;
            if ({x, o} !== {8'(xs[i]), 1'b0}) begin
                fails++;
                $display("FAIL impulse[%0d]: x=%0d ovf=%b want x=%0d ovf=0", i, x, o, xs[i]);
            end
        end
    endtask

    // y obtained by running x = 5,-3,127,-128,0 through h = {1,2,3,4}
    task automatic test_loopback();
        int ys [5] = '{5, 7, 136, 137, 113};
        int xs [5] = '{5, -3, 127, -128, 0};
        logic signed [7:0] x;
        logic o;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_sample(16'(ys[i]), x, o, lat);
            tests++;
            if ({x, o} !== {8'(xs[i]), 1'b0} || lat !== 4) begin
                fails++;
                $display("FAIL loopback[%0d]: x=%0d ovf=%b lat=%0d want x=%0d ovf=0 lat=4",
                         i, x, o, lat, xs[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int ys [3] = '{1000, 254, -1000};
        int xs [3] = '{127, 0, -128};
        logic os [3] = '{1'b1, 1'b0, 1'b1};
        logic signed [7:0] x;
        logic o;
        int lat;
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            run_sample(16'(ys[i]), x, o, lat);
            tests++;
            if ({x, o} !== {8'(xs[i]), os[i]} || lat !== 4) begin
                fails++;
                $display("FAIL overflow[%0d]: x=%0d ovf=%b lat=%0d want x=%0d ovf=%b lat=4",
                         i, x, o, lat, xs[i], os[i]);
            end
        end
    endtask

    // y_valid held high for 20 edges: accepts at edges 1,6,11,16; x_valid after 5,10,15,20
    task automatic test_back_to_back();
        int acc_cnt, xv_cnt, bad;
        int ovf_cnt;
        acc_cnt = 0; xv_cnt = 0; bad = 0; ovf_cnt = 0;
        pulse_clear();
        y_in    = 16'sd0;
        y_valid = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            if (e == 21) y_valid = 1'b0;
            if (y_ready && y_valid) begin
                acc_cnt++;
                if ((e - 1) % 5 != 0) bad++;
            end
            @(posedge clk); #1;
            if (x_valid) begin
                xv_cnt++;
                if (e < 5 || (e - 5) % 5 != 0) bad++;
            end
            if (ovf) ovf_cnt++;
        end
        tests++;
        if (acc_cnt !== 4) begin
            fails++;
            $display("FAIL b2b accepts: got %0d want 4", acc_cnt);
        end
        tests++;
        if (xv_cnt !== 4) begin
            fails++;
            $display("FAIL b2b x_valid pulses: got %0d want 4", xv_cnt);
        end
        tests++;
        if (bad !== 0 || ovf_cnt !== 0) begin
            fails++;
            $display("FAIL b2b timing: misplaced events=%0d ovf pulses=%0d want 0 0", bad, ovf_cnt);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [7:0] x;
        logic o;
        int lat, xv_cnt;
        pulse_clear();
        run_sample(16'sd50, x, o, lat);
        tests++;
        if ({x, o} !== {8'sd50, 1'b0}) begin
            fails++;
            $display("FAIL rstmac seed: x=%0d ovf=%b want 50 0", x, o);
        end
        y_in = 16'sd100; y_valid = 1'b1;
        @(posedge clk); #1;
        y_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({x_out, x_valid, ovf, y_ready} !== {8'sd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rstmac outputs: x_out=%0d x_valid=%b ovf=%b y_ready=%b want 0 0 0 1",
                     x_out, x_valid, ovf, y_ready);
        end
        rst = 1'b0;
        xv_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (x_valid) xv_cnt++;
        end
        tests++;
        if (xv_cnt !== 0) begin
            fails++;
            $display("FAIL rstmac aborted x_valid: got %0d pulses want 0", xv_cnt);
        end
        run_sample(16'sd7, x, o, lat);
        tests++;
        if ({x, o} !== {8'sd7, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL rstmac after: x=%0d ovf=%b lat=%0d want 7 0 4", x, o, lat);
        end
    endtask

    // History entering is [7,0,0]; y=9 gives 9-2*7 = -5
    task automatic test_clear_priority();
        logic signed [7:0] x;
        logic o;
        int lat, xv_cnt;
        run_sample(16'sd9, x, o, lat);
        tests++;
        if ({x, o} !== {-8'sd5, 1'b0}) begin
            fails++;
            $display("FAIL clear seed: x=%0d ovf=%b want -5 0", x, o);
        end
        y_in = 16'sd55; y_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        y_valid = 1'b0; clear = 1'b0;
        tests++;
        if (y_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear accept: y_ready=%b want 1 (sample must be dropped)", y_ready);
        end
        xv_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (x_valid) xv_cnt++;
        end
        tests++;
        if (xv_cnt !== 0) begin
            fails++;
            $display("FAIL clear x_valid: got %0d pulses want 0", xv_cnt);
        end
        run_sample(16'sd2, x, o, lat);
        tests++;
        if ({x, o} !== {8'sd2, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL clear history: x=%0d ovf=%b lat=%0d want 2 0 4", x, o, lat);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_impulse();
        test_loopback();
        test_overflow();
        test_back_to_back();
        test_reset_mid_mac();
        test_clear_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
